horizontal_timing_gen: RTL and testbench
========================================

Name: horizontal_timing_gen

Overview:
- Horizontal pixel-rate timing stage for the 800x600 VGA path.
- Counts pixel clocks across one scan line and produces the horizontal count, active-low HSYNC and HBLANK, and the phase of the line.
- Produces a line-rate tick that directly clocks the downstream vertical counter (which advances on the falling edge of its clock input).
- Also drives the pixel/colour stage with H_COUNT and blank.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, front-porch pixels
- H_SYNC, 128, sync-pulse pixels
- H_BACK, 88, back-porch pixels
- CNT_W, 11, counter width; must satisfy 2^CNT_W >= H_ACTIVE+H_FRONT+H_SYNC+H_BACK

Ports:
- CLK_IN  in  1  pixel clock (40 MHz nominal); all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- PIX_EN  in  1  pixel clock enable; state advances only when high
- H_COUNT  out  CNT_W  current pixel index, 0..H_TOTAL-1
- ACTIVE_LOW_HSYNC  out  1  0 during sync pulse
- ACTIVE_LOW_HBLANK  out  1  0 outside visible region
- H_PHASE  out  2  line phase encoding: 0 ACTIVE, 1 FRONT, 2 SYNC, 3 BACK
- LINE_TICK  out  1  high while H_COUNT == H_TOTAL-1; its falling edge marks line start

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (1056 default). Boundaries:
  - S_FRONT = H_ACTIVE
  - S_SYNC = S_FRONT+H_FRONT
  - S_BACK = S_SYNC+H_SYNC
- Reset: sampled on rising CLK_IN when RST_N=0, overriding PIX_EN. Reset values:
  - H_COUNT=0, H_PHASE=ACTIVE
  - ACTIVE_LOW_HSYNC=1, ACTIVE_LOW_HBLANK=1, LINE_TICK=0
- Reset mid-line: the next cycle after release, output H_COUNT=0 with phase ACTIVE. No partial sync pulse is extended.
- Counter: when PIX_EN=1, H_COUNT <= (H_COUNT==H_TOTAL-1) ? 0 : H_COUNT+1. Wrap is exact; values >= H_TOTAL are never produced.
- When PIX_EN=0, every output holds its value, including LINE_TICK.
- All outputs are registered and mutually aligned: each flag describes the H_COUNT value presented in the same cycle. Implement this by decoding from the next-count value, so there is zero cycle skew between H_COUNT and the flags.
- Decodes for the presented count c:
  - ACTIVE_LOW_HBLANK=0 iff c >= H_ACTIVE
  - ACTIVE_LOW_HSYNC=0 iff S_SYNC <= c < S_BACK
  - LINE_TICK=1 iff c == H_TOTAL-1
- Phase FSM, advancing only on enabled cycles:
  - ACTIVE -> FRONT when next count == S_FRONT
  - FRONT -> SYNC when next count == S_SYNC
  - SYNC -> BACK when next count == S_BACK
  - BACK -> ACTIVE when next count == 0
  - A zero-length porch (H_FRONT=0 or H_BACK=0) skips that state. Transition priority is evaluated so that the phase always matches the range decode.
- H_PHASE must always be consistent with the flags:
  - SYNC implies HSYNC=0
  - ACTIVE implies HBLANK=1
- Downstream contract: LINE_TICK is high for exactly one enabled cycle per line. Its falling edge coincides with H_COUNT returning to 0, giving the vertical stage one negedge per line (1056 pixel clocks at PIX_EN=1).

Decomposition:
- Shared package vga_timing_pkg holds:
  - the default 800x600@60 constants (H_*, V_* values)
  - H_PHASE encodings (PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK)
- One optional sub-module, h_phase_fsm: next-count decode plus phase register.
- Counter and output flops stay in the top module.

Test Plan:
- Reset then PIX_EN=1 for 1056 cycles:
  - H_COUNT runs 0..1055 and wraps to 0
  - HBLANK_N=0 exactly for counts 800..1055
  - HSYNC_N=0 exactly for counts 840..967 (128 cycles)
  - LINE_TICK=1 only at count 1055
- PIX_EN toggling 1/0 every cycle over 2 lines: the count advances only on enabled cycles. One line takes 2112 clocks, and LINE_TICK stays high for 2 clocks at count 1055.
- Assert RST_N=0 at count 900 (inside sync): the next cycle shows H_COUNT=0, HSYNC_N=1, HBLANK_N=1, H_PHASE=0. Resume produces a full-length sync at 840.
- RST_N=0 with PIX_EN=0: reset still takes effect and all outputs take their reset values.
- Connect the vertical counter to LINE_TICK and run 629 lines: the vertical count increments once per line, starting at the H_COUNT 1055->0 transition.
- Run with parameters H_FRONT=0, H_BACK=0: the phase sequence is ACTIVE->SYNC->ACTIVE with no FRONT/BACK state, HSYNC_N=0 for counts 800..927, and H_TOTAL=928.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 800x600@60 timing constants and horizontal phase encoding.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned H_FRONT_DEF  = 40;
  localparam int unsigned H_SYNC_DEF   = 128;
  localparam int unsigned H_BACK_DEF   = 88;

  localparam int unsigned V_ACTIVE_DEF = 600;
  localparam int unsigned V_FRONT_DEF  = 1;
  localparam int unsigned V_SYNC_DEF   = 4;
  localparam int unsigned V_BACK_DEF   = 23;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } h_phase_e;

  function automatic int unsigned h_total_def();
    return H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  endfunction

  function automatic int unsigned v_total_def();
    return V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  endfunction

endpackage

// File: rtl/horizontal_timing_gen_if.sv
// Horizontal timing bus: pixel enable in, count/sync/blank/phase/tick out.
interface horizontal_timing_gen_if #(
  parameter int unsigned CNT_W = 11
);
  logic             PIX_EN;
  logic [CNT_W-1:0] H_COUNT;
  logic             ACTIVE_LOW_HSYNC;
  logic             ACTIVE_LOW_HBLANK;
  logic [1:0]       H_PHASE;
  logic             LINE_TICK;

  modport master (
    input  PIX_EN,
    output H_COUNT,
    output ACTIVE_LOW_HSYNC,
    output ACTIVE_LOW_HBLANK,
    output H_PHASE,
    output LINE_TICK
  );

  modport slave (
    output PIX_EN,
    input  H_COUNT,
    input  ACTIVE_LOW_HSYNC,
    input  ACTIVE_LOW_HBLANK,
    input  H_PHASE,
    input  LINE_TICK
  );
endinterface

// File: rtl/h_phase_fsm.sv
// Next-count decode and registered line-phase state, advancing on enabled cycles.
module h_phase_fsm
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [CNT_W-1:0] count_next_o,
  output h_phase_e         phase_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned SFront = H_ACTIVE;
  localparam int unsigned SSync  = SFront + H_FRONT;
  localparam int unsigned SBack  = SSync + H_SYNC;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] FrontCnt = CNT_W'(SFront);
  localparam logic [CNT_W-1:0] SyncCnt  = CNT_W'(SSync);
  localparam logic [CNT_W-1:0] BackCnt  = CNT_W'(SBack);

  h_phase_e phase_q, phase_d;

  always_comb begin
    count_next_o = count_i;
    if (en_i) begin
      count_next_o = (count_i == LastCnt) ? '0 : count_i + 1'b1;
    end
  end

  // Zero-length porches collapse their start onto the next boundary, so skip straight past them.
  always_comb begin
    phase_d = phase_q;
    if (en_i) begin
      unique case (phase_q)
        PH_ACTIVE: begin
          if (count_next_o == FrontCnt) phase_d = (H_FRONT == 0) ? PH_SYNC : PH_FRONT;
        end
        PH_FRONT: begin
          if (count_next_o == SyncCnt) phase_d = PH_SYNC;
        end
        PH_SYNC: begin
          if (count_next_o == '0) phase_d = PH_ACTIVE;
          else if (H_BACK != 0 && count_next_o == BackCnt) phase_d = PH_BACK;
        end
        PH_BACK: begin
          if (count_next_o == '0) phase_d = PH_ACTIVE;
        end
        default: phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) phase_q <= PH_ACTIVE;
    else         phase_q <= phase_d;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/horizontal_timing_gen.sv
// Horizontal pixel counter with registered sync/blank/tick flags aligned to the presented count.
module horizontal_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF,
  parameter int unsigned CNT_W    = 11
) (
  input  logic                    CLK_IN,
  input  logic                    RST_N,
  horizontal_timing_gen_if.master bus
);

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned SSync  = H_ACTIVE + H_FRONT;
  localparam int unsigned SBack  = SSync + H_SYNC;

  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] ActiveCnt = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] SyncCnt   = CNT_W'(SSync);
  localparam logic [CNT_W-1:0] BackCnt   = CNT_W'(SBack);

  logic [CNT_W-1:0] count_q, count_d;
  logic             hsync_n_q, hblank_n_q, tick_q;
  h_phase_e         phase;

  h_phase_fsm #(
    .CNT_W    (CNT_W),
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK)
  ) u_phase (
    .clk_i        (CLK_IN),
    .rst_ni       (RST_N),
    .en_i         (bus.PIX_EN),
    .count_i      (count_q),
    .count_next_o (count_d),
    .phase_o      (phase)
  );

  // Flags decode count_d so they land in the same cycle as the count they describe.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      count_q    <= '0;
      hsync_n_q  <= 1'b1;
      hblank_n_q <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      hblank_n_q <= !(count_d >= ActiveCnt);
      hsync_n_q  <= !((count_d >= SyncCnt) && (count_d < BackCnt));
      tick_q     <= (count_d == LastCnt);
    end
  end

  assign bus.H_COUNT           = count_q;
  assign bus.ACTIVE_LOW_HSYNC  = hsync_n_q;
  assign bus.ACTIVE_LOW_HBLANK = hblank_n_q;
  assign bus.H_PHASE           = phase;
  assign bus.LINE_TICK         = tick_q;

endmodule

// File: tb/tb_horizontal_timing_gen.sv
// Randomized and directed check of horizontal_timing_gen against an arithmetic line model.
module tb_horizontal_timing_gen;

  localparam int TA = 1056;  // default line
  localparam int TB = 928;   // no porches

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  horizontal_timing_gen_if #(.CNT_W(11)) bus_a ();
  horizontal_timing_gen_if #(.CNT_W(11)) bus_b ();

  assign bus_a.PIX_EN = pix_en;
  assign bus_b.PIX_EN = pix_en;

  horizontal_timing_gen #(
    .H_ACTIVE (800), .H_FRONT (40), .H_SYNC (128), .H_BACK (88), .CNT_W (11)
  ) u_dut_a (
    .CLK_IN (clk),
    .RST_N  (rst_n),
    .bus    (bus_a)
  );

  horizontal_timing_gen #(
    .H_ACTIVE (800), .H_FRONT (0), .H_SYNC (128), .H_BACK (0), .CNT_W (11)
  ) u_dut_b (
    .CLK_IN (clk),
    .RST_N  (rst_n),
    .bus    (bus_b)
  );

  // Downstream vertical stage stand-in: advances on each falling edge of the line tick.
  int v_cnt = 0;
  always @(negedge bus_a.LINE_TICK) v_cnt <= v_cnt + 1;

  int n_checks = 0;
  int n_bad = 0;
  int ma = 0, mb = 0;
  int lines_exp = 0;

  int hb_low, hs_low, hs_low_b, tick_clk, first_low;
  bit saw_front_b = 0, saw_back_b = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_phase(input int c, input int sf, input int ss, input int sb);
    if (c < sf) return 0;
    if (c < ss) return 1;
    if (c < sb) return 2;
    return 3;
  endfunction

  task automatic check_outs();
    check_eq("a.count",  int'(bus_a.H_COUNT), ma);
    check_eq("a.hblank", int'(bus_a.ACTIVE_LOW_HBLANK), (ma >= 800) ? 0 : 1);
    check_eq("a.hsync",  int'(bus_a.ACTIVE_LOW_HSYNC), (ma >= 840 && ma < 968) ? 0 : 1);
    check_eq("a.tick",   int'(bus_a.LINE_TICK), (ma == TA - 1) ? 1 : 0);
    check_eq("a.phase",  int'(bus_a.H_PHASE), exp_phase(ma, 800, 840, 968));
    check_eq("b.count",  int'(bus_b.H_COUNT), mb);
    check_eq("b.hblank", int'(bus_b.ACTIVE_LOW_HBLANK), (mb >= 800) ? 0 : 1);
    check_eq("b.hsync",  int'(bus_b.ACTIVE_LOW_HSYNC), (mb >= 800 && mb < 928) ? 0 : 1);
    check_eq("b.tick",   int'(bus_b.LINE_TICK), (mb == TB - 1) ? 1 : 0);
    check_eq("b.phase",  int'(bus_b.H_PHASE), exp_phase(mb, 800, 800, 928));
  endtask

  task automatic step(input logic en, input logic rn);
    bit tick_before;
    pix_en = en;
    rst_n  = rn;
    @(posedge clk);
    #1;
    tick_before = (ma == TA - 1);
    if (!rn) begin
      ma = 0;
      mb = 0;
    end else if (en) begin
      ma = (ma == TA - 1) ? 0 : ma + 1;
      mb = (mb == TB - 1) ? 0 : mb + 1;
    end
    if (tick_before && ma != TA - 1) lines_exp++;
    if (bus_b.H_PHASE == 2'd1) saw_front_b = 1;
    if (bus_b.H_PHASE == 2'd3) saw_back_b = 1;
    check_outs();
  endtask

  initial begin
    int v_base;
    int guard;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    v_base = v_cnt;
    lines_exp = 0;

    // One full line at full rate
    hb_low = 0; hs_low = 0; hs_low_b = 0; tick_clk = 0;
    for (int i = 0; i < TA; i++) begin
      step(1'b1, 1'b1);
      if (!bus_a.ACTIVE_LOW_HBLANK) hb_low++;
      if (!bus_a.ACTIVE_LOW_HSYNC) hs_low++;
      if (!bus_b.ACTIVE_LOW_HSYNC) hs_low_b++;
      if (bus_a.LINE_TICK) tick_clk++;
    end
    check_eq("line.hblank_low", hb_low, 256);
    check_eq("line.hsync_low", hs_low, 128);
    check_eq("line.tick_clks", tick_clk, 1);
    check_eq("line.b_hsync_low", hs_low_b, 128);

    // Enable toggling every cycle over two lines
    tick_clk = 0;
    for (int i = 0; i < 4 * TA; i++) begin
      step((i % 2) == 0, 1'b1);
      if (bus_a.LINE_TICK) tick_clk++;
    end
    check_eq("toggle.tick_clks", tick_clk, 4);
    check_eq("toggle.end_count", int'(bus_a.H_COUNT), 0);

    // Reset inside the sync pulse
    guard = 0;
    while (ma != 900 && guard < 2 * TA) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check_eq("rst_sync.reached_900", ma, 900);
    step(1'b1, 1'b0);
    hs_low = 0; first_low = -1;
    for (int i = 0; i < TA; i++) begin
      step(1'b1, 1'b1);
      if (!bus_a.ACTIVE_LOW_HSYNC) begin
        hs_low++;
        if (first_low < 0) first_low = int'(bus_a.H_COUNT);
      end
    end
    check_eq("rst_sync.hsync_len", hs_low, 128);
    check_eq("rst_sync.hsync_start", first_low, 840);

    // Reset with enable low
    for (int i = 0; i < 300 + int'($urandom_range(0, 500)); i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Random enable with rare resets
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 599) != 0);
    end

    // Full-rate tail so the vertical stage sees several clean lines
    for (int i = 0; i < 3 * TA; i++) step(1'b1, 1'b1);
    #1;
    check_eq("vert.line_count", v_cnt - v_base, lines_exp);
    check_eq("b.no_front_phase", int'(saw_front_b), 0);
    check_eq("b.no_back_phase", int'(saw_back_b), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
